mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller for the pipelined MIPS CPU; owns the HI/LO registers.
- Accepts one mult/multu/div/divu operation per start pulse and holds busy for a fixed latency. It then commits the result to HI/LO and pulses done.
- Serialises all HI/LO access between the arithmetic path and mthi/mtlo writes. The stall unit uses busy to freeze E-stage MDU instructions.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for mult/multu (>=1).
- DIV_CYCLES, 10, cycles busy stays high for div/divu (>=1).
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  launch operation; sampled only in IDLE.
- op  in  2  00 mult, 01 multu, 10 div, 11 divu.
- a  in  32  rs operand (multiplicand / dividend).
- b  in  32  rt operand (multiplier / divisor).
- we_hi  in  1  mthi write strobe.
- we_lo  in  1  mtlo write strobe.
- wdata  in  32  mthi/mtlo data.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse on the cycle HI/LO take the result.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, pending regs=0.
- Reset mid-operation aborts: the result is discarded and HI/LO are cleared to 0.
- States are IDLE and RUN.
- IDLE, start=1 at edge T:
  - Compute the 64-bit result from a, b, op and latch it into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES. Go to RUN.
  - busy=1 from T+1.
- RUN: counter decrements each edge. At the edge where counter==1:
  - hi<=pending_hi, lo<=pending_lo, state<=IDLE.
  - busy=0 and done=1 in the following cycle.
- Net effect: for latency N, busy is high exactly N cycles and HI/LO are visible N cycles after the start edge.
- Arithmetic:
  - mult: signed 32x32 to 64; hi=[63:32], lo=[31:0].
  - multu: same, unsigned.
  - div: lo=signed quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - 0x80000000 div 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - divu: unsigned quotient and remainder.
  - Divide by zero (b==0): still runs the full DIV_CYCLES and pulses done, but HI/LO remain unchanged.
- mthi/mtlo:
  - In IDLE with start=0: we_hi/we_lo write wdata into hi/lo at the next edge. Both asserted writes both.
  - In RUN: writes are ignored; the stall unit is responsible for preventing them.
  - start and we_* together in IDLE: start wins and the writes are dropped.
- start while RUN is ignored: no restart, no queueing.
- done is 0 in every cycle except the single commit cycle.
- hi/lo are combinational reads of the registers, with no extra latency.

Decomposition:
- Shared package (cpu_defs) holds:
  - MDU_OP_MULT=2'b00, MDU_OP_MULTU=2'b01, MDU_OP_DIV=2'b10, MDU_OP_DIVU=2'b11.
  - Default latencies 5 and 10.
- One natural sub-module, mdu_calc: purely combinational 64-bit result generation from a, b, op, plus a div_by_zero flag.
- mdu_ctrl keeps the FSM, counter, pending registers and HI/LO.

Test Plan:
- Reset, then idle: busy=0, done=0, hi=lo=0.
- mult, a=0xFFFFFFFE (-2), b=3, start at T: busy=1 at T+1..T+5; at T+5 done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands gives hi=0x2, lo=0xFFFFFFFA.
- div, a=-7, b=2: after 10 cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu 7/2 gives lo=3, hi=1.
- Preload via mthi=0x1234, mtlo=0x5678, then div by b=0: busy for 10 cycles, done pulses, hi=0x1234, lo=0x5678 unchanged.
- During RUN, pulse start with new operands and we_hi=1, wdata=0xDEAD: the original result commits unaffected and the latency is unchanged.
- Assert reset at the 3rd busy cycle of a mult: next cycle busy=0, hi=lo=0, and no done pulse ever occurs.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: MDU opcodes, default latencies and MDU state encoding.
package cpu_defs;

   localparam logic [1:0] MDU_OP_MULT  = 2'b00;
   localparam logic [1:0] MDU_OP_MULTU = 2'b01;
   localparam logic [1:0] MDU_OP_DIV   = 2'b10;
   localparam logic [1:0] MDU_OP_DIVU  = 2'b11;

   localparam int MDU_MULT_LAT = 5;
   localparam int MDU_DIV_LAT  = 10;

   typedef enum logic {
      MDU_IDLE = 1'b0,
      MDU_RUN  = 1'b1
   } mdu_state_e;

endpackage

// File: rtl/mdu_calc.sv
// Combinational MDU datapath: 64-bit {hi,lo} result for mult/multu/div/divu.
module mdu_calc
   import cpu_defs::*;
(
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] res,
   output logic        div_by_zero
);

   logic        is_div_s;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] divisor;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] quo_s;
   logic [31:0] rem_s;
   logic [63:0] ext_a;
   logic [63:0] ext_b;
   logic [63:0] prod;

   assign is_div_s    = (op == MDU_OP_DIV);
   assign a_neg       = is_div_s & a[31];
   assign b_neg       = is_div_s & b[31];
   assign div_by_zero = op[1] & (b == 32'd0);

   // Divide on magnitudes so 0x80000000 / -1 wraps back to 0x80000000.
   assign mag_a   = a_neg ? -a : a;
   assign mag_b   = b_neg ? -b : b;
   assign divisor = (mag_b == 32'd0) ? 32'd1 : mag_b;
   assign quo     = mag_a / divisor;
   assign rem     = mag_a % divisor;
   assign quo_s   = (a_neg ^ b_neg) ? -quo : quo;
   assign rem_s   = a_neg ? -rem : rem;

   assign ext_a = (op == MDU_OP_MULT) ? {{32{a[31]}}, a} : {32'd0, a};
   assign ext_b = (op == MDU_OP_MULT) ? {{32{b[31]}}, b} : {32'd0, b};
   assign prod  = ext_a * ext_b;

   always_comb begin
      res = prod;
      if (op[1]) begin
         res = {rem_s, quo_s};
      end
   end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller owning HI/LO; fixed latency per op,
// result held in pending registers and committed with a one-cycle done pulse.
module mdu_ctrl
   import cpu_defs::*;
#(
   parameter int MULT_CYCLES = MDU_MULT_LAT,
   parameter int DIV_CYCLES  = MDU_DIV_LAT,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        we_hi,
   input  logic        we_lo,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   mdu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      pend_hi_q, pend_hi_d;
   logic [31:0]      pend_lo_q, pend_lo_d;
   logic             dbz_q, dbz_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic             done_q, done_d;

   logic [63:0]      calc_res;
   logic             calc_dbz;

   mdu_calc u_calc (
      .op          (op),
      .a           (a),
      .b           (b),
      .res         (calc_res),
      .div_by_zero (calc_dbz)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      dbz_d     = dbz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      unique case (state_q)
         MDU_IDLE: begin
            if (start) begin
               pend_hi_d = calc_res[63:32];
               pend_lo_d = calc_res[31:0];
               dbz_d     = calc_dbz;
               cnt_d     = op[1] ? CNT_W'(DIV_CYCLES)
                                 : CNT_W'(MULT_CYCLES);
               state_d   = MDU_RUN;
            end else begin
               if (we_hi) hi_d = wdata;
               if (we_lo) lo_d = wdata;
            end
         end
         MDU_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = MDU_IDLE;
               done_d  = 1'b1;
               // Divide by zero leaves HI/LO untouched.
               if (!dbz_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
            end
         end
         default: state_d = MDU_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= MDU_IDLE;
         cnt_q     <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         dbz_q     <= dbz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign busy = (state_q == MDU_RUN);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with hand-computed HI/LO values.
module tb_mdu_ctrl;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        we_hi;
   logic        we_lo;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_chk;
   int n_pass;

   mdu_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .we_hi (we_hi),
      .we_lo (we_lo),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Launch one op, watch busy/done cycle by cycle, then check HI/LO.
   // with_we: assert we_hi/we_lo alongside start; mid_run: poke inputs in RUN.
   task automatic run_op(input string tag,
                         input logic [1:0] o,
                         input logic [31:0] x,
                         input logic [31:0] y,
                         input int n,
                         input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo,
                         input logic with_we,
                         input logic mid_run);
      int bad_busy;
      bad_busy = 0;
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      we_hi = with_we;
      we_lo = with_we;
      wdata = 32'hDEAD_0000;
      @(negedge clk);
      start = 1'b0;
      we_hi = 1'b0;
      we_lo = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
         if (mid_run && i == 2) begin
            start = 1'b1;
            op    = 2'b11;
            a     = 32'd100;
            b     = 32'd7;
            we_hi = 1'b1;
            wdata = 32'h0000_DEAD;
         end else begin
            start = 1'b0;
            we_hi = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      we_hi = 1'b0;
      check({tag, " busy_window_errs"}, 32'(bad_busy), 32'd0);
      check({tag, " busy_after"}, {31'd0, busy}, 32'd0);
      check({tag, " done"}, {31'd0, done}, 32'd1);
      check({tag, " hi"}, hi, exp_hi);
      check({tag, " lo"}, lo, exp_lo);
      @(negedge clk);
      check({tag, " done_drop"}, {31'd0, done}, 32'd0);
   endtask

   task automatic mt_write(input logic wh, input logic wl,
                           input logic [31:0] d);
      we_hi = wh;
      we_lo = wl;
      wdata = d;
      @(negedge clk);
      we_hi = 1'b0;
      we_lo = 1'b0;
   endtask

   initial begin
      int done_seen;
      n_chk  = 0;
      n_pass = 0;
      reset  = 1'b1;
      start  = 1'b0;
      op     = 2'b00;
      a      = '0;
      b      = '0;
      we_hi  = 1'b0;
      we_lo  = 1'b0;
      wdata  = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst done", {31'd0, done}, 32'd0);
      check("rst hi", hi, 32'd0);
      check("rst lo", lo, 32'd0);

      run_op("mult", 2'b00, 32'hFFFF_FFFE, 32'd3, 5,
             32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b0);
      run_op("multu", 2'b01, 32'hFFFF_FFFE, 32'd3, 5,
             32'h0000_0002, 32'hFFFF_FFFA, 1'b0, 1'b0);
      run_op("div", 2'b10, 32'hFFFF_FFF9, 32'd2, 10,
             32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
      run_op("divu", 2'b11, 32'd7, 32'd2, 10,
             32'd1, 32'd3, 1'b0, 1'b0);
      run_op("div_negb", 2'b10, 32'd7, 32'hFFFF_FFFE, 10,
             32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0);
      run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10,
             32'd0, 32'h8000_0000, 1'b0, 1'b0);

      mt_write(1'b1, 1'b0, 32'h0000_1234);
      mt_write(1'b0, 1'b1, 32'h0000_5678);
      check("mthi", hi, 32'h0000_1234);
      check("mtlo", lo, 32'h0000_5678);
      run_op("div0", 2'b10, 32'd55, 32'd0, 10,
             32'h0000_1234, 32'h0000_5678, 1'b0, 1'b0);
      run_op("div0_we", 2'b11, 32'd9, 32'd0, 10,
             32'h0000_1234, 32'h0000_5678, 1'b1, 1'b0);

      mt_write(1'b1, 1'b1, 32'hCAFE_F00D);
      check("mt_both hi", hi, 32'hCAFE_F00D);
      check("mt_both lo", lo, 32'hCAFE_F00D);

      run_op("midrun", 2'b00, 32'd5, 32'd7, 5,
             32'd0, 32'd35, 1'b0, 1'b1);

      start = 1'b1;
      op    = 2'b00;
      a     = 32'd9;
      b     = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort hi", hi, 32'd0);
      check("abort lo", lo, 32'd0);
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (done === 1'b1 || busy === 1'b1) done_seen++;
         @(negedge clk);
      end
      check("abort no_done", 32'(done_seen), 32'd0);
      check("abort lo_kept", lo, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
